alu_arbiter: RTL

Shares the single combinational `alu` between NUM_REQ requesters (e.g. execute stage, address generator, CSR unit) in the RISC-V core. Arbitrates round-robin, registers operands, sequences one ALU evaluation per grant, and returns a registered result via a per-requester valid/ready response channel. The `alu` instance sits in the parent; this block drives its inputs and samples its outputs.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/alu_arbiter_rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU op codes, arbiter FSM states, datapath width.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    SRA  = 4'd4,
    SLT  = 4'd5,
    XOR  = 4'd6,
    SLL  = 4'd7,
    SLTU = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters (master) and the ALU arbiter (slave).
interface alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    import alu_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [ALU_W*NUM_REQ-1:0] req_a;
    logic [ALU_W*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0]     req_op;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [ALU_W-1:0]         resp_result;
    logic                     resp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping around.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand     = (32'(ptr_i) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU among NUM_REQ requesters, one op in flight.
// Optional per-requester saturating grant counters under `define ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    alu_arbiter_if.slave             bus,
    output logic [ALU_W-1:0]         alu_src_a,
    output logic [ALU_W-1:0]         alu_src_b,
    output logic [3:0]               alu_ctrl,
    input  logic [ALU_W-1:0]         alu_result,
    input  logic                     alu_zero,
    output logic [CNT_W*NUM_REQ-1:0] grant_cnt
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q;
    logic [ALU_W-1:0]   a_q, b_q, result_q;
    logic [3:0]         op_q;
    logic               zero_q;
    logic [NUM_REQ-1:0] resp_valid_q;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [ALU_W-1:0]   sel_a, sel_b;
    logic [3:0]         sel_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_a  = bus.req_a[i*ALU_W +: ALU_W];
                sel_b  = bus.req_b[i*ALU_W +: ALU_W];
                sel_op = bus.req_op[i*4 +: 4];
            end
        end
        rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // reset_n gating keeps req_ready low while reset is held, even with requests pending
    assign bus.req_ready   = (state_q == IDLE && reset_n) ? gnt : '0;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    assign alu_src_a       = a_q;
    assign alu_src_b       = b_q;
    assign alu_ctrl        = op_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        op_q     <= sel_op;
                        grant_q  <= gnt_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    result_q     <= alu_result;
                    zero_q       <= alu_zero;
                    resp_valid_q <= NUM_REQ'(1) << grant_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready[grant_q]) begin
                        resp_valid_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = '0;
`endif

endmodule
